// File: rtl/ex_alu.sv
// ex_alu: MIPS III execute stage -- integer ALU, shifter, address adder and branch comparator.
// Every output is registered with exactly one cycle of latency. Kill and async reset both zero the outputs.
module ex_alu #(
  parameter int DECMAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DECMAX:0] exdec,
  input  logic [31:0]     exinstr,
  input  logic [63:0]     exr0,
  input  logic [63:0]     exr1,
  input  logic [63:0]     exlink,
  output logic [63:0]     exalur,
  output logic            exovfl,
  output logic            exbcmp
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_COP1    = 6'h11;
  localparam logic [5:0] OP_COP1X   = 6'h13;
  localparam logic [5:0] OP_BEQL    = 6'h14;
  localparam logic [5:0] OP_BNEL    = 6'h15;
  localparam logic [5:0] OP_BLEZL   = 6'h16;
  localparam logic [5:0] OP_BGTZL   = 6'h17;
  localparam logic [5:0] OP_DADDI   = 6'h18;
  localparam logic [5:0] OP_DADDIU  = 6'h19;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  sa;
  logic [63:0] simm;
  logic [63:0] zimm;
  logic [31:0] r1w;
  logic [31:0] sum32;
  logic [31:0] dif32;
  logic [31:0] sumi32;
  logic [63:0] sum64;
  logic [63:0] dif64;
  logic [63:0] sumi64;
  logic        ovf_add32;
  logic        ovf_sub32;
  logic        ovf_addi32;
  logic        ovf_add64;
  logic        ovf_sub64;
  logic        ovf_addi64;
  logic        r0_neg;
  logic        r0_zero;
  logic        r0_eq_r1;
  logic [63:0] alur_d;
  logic [63:0] alur_q;
  logic        ovfl_d;
  logic        ovfl_q;
  logic        bcmp_d;
  logic        bcmp_q;
  logic        unused_bits;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [31:0] sra32(input logic [31:0] v, input logic [4:0] n);
    return $signed(v) >>> n;
  endfunction

  assign op   = exinstr[31:26];
  assign fn   = exinstr[5:0];
  assign rt   = exinstr[20:16];
  assign sa   = exinstr[10:6];
  assign simm = {{48{exinstr[15]}}, exinstr[15:0]};
  assign zimm = {48'd0, exinstr[15:0]};
  assign r1w  = exr1[31:0];

  assign sum32  = exr0[31:0] + exr1[31:0];
  assign dif32  = exr0[31:0] - exr1[31:0];
  assign sumi32 = exr0[31:0] + simm[31:0];
  assign sum64  = exr0 + exr1;
  assign dif64  = exr0 - exr1;
  assign sumi64 = exr0 + simm;

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
  assign ovf_add32  = (exr0[31] == exr1[31]) && (sum32[31]  != exr0[31]);
  assign ovf_sub32  = (exr0[31] != exr1[31]) && (dif32[31]  != exr0[31]);
  assign ovf_addi32 = (exr0[31] == simm[31]) && (sumi32[31] != exr0[31]);
  assign ovf_add64  = (exr0[63] == exr1[63]) && (sum64[63]  != exr0[63]);
  assign ovf_sub64  = (exr0[63] != exr1[63]) && (dif64[63]  != exr0[63]);
  assign ovf_addi64 = (exr0[63] == simm[63]) && (sumi64[63] != exr0[63]);

  assign r0_neg   = exr0[63];
  assign r0_zero  = (exr0 == 64'd0);
  assign r0_eq_r1 = (exr0 == exr1);

  assign unused_bits = ^{exdec[DECMAX:1], exinstr[25:21]};

  always_comb begin
    alur_d = '0;
    ovfl_d = 1'b0;
    bcmp_d = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          6'h00: alur_d = sext32(r1w << sa);
          6'h02: alur_d = sext32(r1w >> sa);
          6'h03: alur_d = sext32(sra32(r1w, sa));
          6'h04: alur_d = sext32(r1w << exr0[4:0]);
          6'h06: alur_d = sext32(r1w >> exr0[4:0]);
          6'h07: alur_d = sext32(sra32(r1w, exr0[4:0]));
          6'h08: bcmp_d = 1'b1;
          6'h09: begin
            alur_d = exlink;
            bcmp_d = 1'b1;
          end
          // HI/LO moves and multiply/divide are executed elsewhere; rt passes through.
          6'h10, 6'h11, 6'h12, 6'h13,
          6'h18, 6'h19, 6'h1A, 6'h1B,
          6'h1C, 6'h1D, 6'h1E, 6'h1F: alur_d = exr1;
          6'h14: alur_d = exr1 << exr0[5:0];
          6'h16: alur_d = exr1 >> exr0[5:0];
          6'h17: alur_d = $signed(exr1) >>> exr0[5:0];
          6'h20: begin
            alur_d = sext32(sum32);
            ovfl_d = ovf_add32;
          end
          6'h21: alur_d = sext32(sum32);
          6'h22: begin
            alur_d = sext32(dif32);
            ovfl_d = ovf_sub32;
          end
          6'h23: alur_d = sext32(dif32);
          6'h24: alur_d = exr0 & exr1;
          6'h25: alur_d = exr0 | exr1;
          6'h26: alur_d = exr0 ^ exr1;
          6'h27: alur_d = ~(exr0 | exr1);
          6'h2A: alur_d = {63'd0, $signed(exr0) < $signed(exr1)};
          6'h2B: alur_d = {63'd0, exr0 < exr1};
          6'h2C: begin
            alur_d = sum64;
            ovfl_d = ovf_add64;
          end
          6'h2D: alur_d = sum64;
          6'h2E: begin
            alur_d = dif64;
            ovfl_d = ovf_sub64;
          end
          6'h2F: alur_d = dif64;
          6'h38: alur_d = exr1 << sa;
          6'h3A: alur_d = exr1 >> sa;
          6'h3B: alur_d = $signed(exr1) >>> sa;
          6'h3C: alur_d = exr1 << {1'b1, sa};
          6'h3E: alur_d = exr1 >> {1'b1, sa};
          6'h3F: alur_d = $signed(exr1) >>> {1'b1, sa};
          default: ;
        endcase
      end
      OP_REGIMM: begin
        // rt[4] selects the linking forms, rt[0] selects >= 0 over < 0.
        case (rt)
          5'h00, 5'h02: bcmp_d = r0_neg;
          5'h01, 5'h03: bcmp_d = !r0_neg;
          5'h10, 5'h12: begin
            bcmp_d = r0_neg;
            alur_d = exlink;
          end
          5'h11, 5'h13: begin
            bcmp_d = !r0_neg;
            alur_d = exlink;
          end
          default: ;
        endcase
      end
      OP_J:   bcmp_d = 1'b1;
      OP_JAL: begin
        alur_d = exlink;
        bcmp_d = 1'b1;
      end
      OP_BEQ,  OP_BEQL:  bcmp_d = r0_eq_r1;
      OP_BNE,  OP_BNEL:  bcmp_d = !r0_eq_r1;
      OP_BLEZ, OP_BLEZL: bcmp_d = r0_neg || r0_zero;
      OP_BGTZ, OP_BGTZL: bcmp_d = !r0_neg && !r0_zero;
      OP_ADDI: begin
        alur_d = sext32(sumi32);
        ovfl_d = ovf_addi32;
      end
      OP_ADDIU: alur_d = sext32(sumi32);
      OP_SLTI:  alur_d = {63'd0, $signed(exr0) < $signed(simm)};
      OP_SLTIU: alur_d = {63'd0, exr0 < simm};
      OP_ANDI:  alur_d = exr0 & zimm;
      OP_ORI:   alur_d = exr0 | zimm;
      OP_XORI:  alur_d = exr0 ^ zimm;
      OP_LUI:   alur_d = {{32{exinstr[15]}}, exinstr[15:0], 16'd0};
      OP_COP0, OP_COP1, OP_COP1X: alur_d = exr1;
      OP_DADDI: begin
        alur_d = sumi64;
        ovfl_d = ovf_addi64;
      end
      OP_DADDIU: alur_d = sumi64;
      // Loads, stores, LL/SC, CACHE and COP1 memory ops: effective address.
      6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
      6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D,
      6'h2E, 6'h2F, 6'h30, 6'h31, 6'h34, 6'h35, 6'h37, 6'h38,
      6'h39, 6'h3C, 6'h3D, 6'h3F: alur_d = sumi64;
      default: ;
    endcase
    if (exdec[0]) begin
      alur_d = '0;
      ovfl_d = 1'b0;
      bcmp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alur_q <= '0;
      ovfl_q <= 1'b0;
      bcmp_q <= 1'b0;
    end else begin
      alur_q <= alur_d;
      ovfl_q <= ovfl_d;
      bcmp_q <= bcmp_d;
    end
  end

  assign exalur = alur_q;
  assign exovfl = ovfl_q;
  assign exbcmp = bcmp_q;

endmodule

// File: tb/tb_ex_alu.sv
// tb_ex_alu: directed checks of the documented cases plus random instructions
// compared against a mnemonic-level reference model of the ALU.
module tb_ex_alu;

  logic        clk;
  logic        reset;
  logic [15:0] exdec;
  logic [31:0] exinstr;
  logic [63:0] exr0;
  logic [63:0] exr1;
  logic [63:0] exlink;
  logic [63:0] exalur;
  logic        exovfl;
  logic        exbcmp;

  int n_tests = 0;
  int n_fail  = 0;

  ex_alu #(.DECMAX(15)) dut (
    .clk     (clk),
    .reset   (reset),
    .exdec   (exdec),
    .exinstr (exinstr),
    .exr0    (exr0),
    .exr1    (exr1),
    .exlink  (exlink),
    .exalur  (exalur),
    .exovfl  (exovfl),
    .exbcmp  (exbcmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {
    M_UNK, M_PASS, M_MEM,
    M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV,
    M_DSLL, M_DSRL, M_DSRA, M_DSLL32, M_DSRL32, M_DSRA32, M_DSLLV, M_DSRLV, M_DSRAV,
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_DADD, M_DADDU, M_DSUB, M_DSUBU,
    M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_ADDI, M_ADDIU, M_DADDI, M_DADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
    M_J, M_JAL, M_JR, M_JALR, M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
    M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL
  } mn_t;

  typedef struct packed {
    logic [63:0] r;
    logic        o;
    logic        c;
  } res_t;

  function automatic mn_t decode(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    op = ins[31:26];
    fn = ins[5:0];
    rt = ins[20:16];
    if (op == 6'h00) begin
      case (fn)
        6'h00: return M_SLL;    6'h02: return M_SRL;    6'h03: return M_SRA;
        6'h04: return M_SLLV;   6'h06: return M_SRLV;   6'h07: return M_SRAV;
        6'h08: return M_JR;     6'h09: return M_JALR;
        6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
        6'h1C, 6'h1D, 6'h1E, 6'h1F: return M_PASS;
        6'h14: return M_DSLLV;  6'h16: return M_DSRLV;  6'h17: return M_DSRAV;
        6'h20: return M_ADD;    6'h21: return M_ADDU;   6'h22: return M_SUB;
        6'h23: return M_SUBU;   6'h24: return M_AND;    6'h25: return M_OR;
        6'h26: return M_XOR;    6'h27: return M_NOR;    6'h2A: return M_SLT;
        6'h2B: return M_SLTU;   6'h2C: return M_DADD;   6'h2D: return M_DADDU;
        6'h2E: return M_DSUB;   6'h2F: return M_DSUBU;  6'h38: return M_DSLL;
        6'h3A: return M_DSRL;   6'h3B: return M_DSRA;   6'h3C: return M_DSLL32;
        6'h3E: return M_DSRL32; 6'h3F: return M_DSRA32;
        default: return M_UNK;
      endcase
    end
    if (op == 6'h01) begin
      case (rt)
        5'h00, 5'h02: return M_BLTZ;
        5'h01, 5'h03: return M_BGEZ;
        5'h10, 5'h12: return M_BLTZAL;
        5'h11, 5'h13: return M_BGEZAL;
        default: return M_UNK;
      endcase
    end
    if (op inside {6'h1A, 6'h1B, [6'h20:6'h2F], 6'h30, 6'h31, 6'h34, 6'h35, 6'h37,
                   6'h38, 6'h39, 6'h3C, 6'h3D, 6'h3F}) return M_MEM;
    case (op)
      6'h02: return M_J;      6'h03: return M_JAL;
      6'h04, 6'h14: return M_BEQ;
      6'h05, 6'h15: return M_BNE;
      6'h06, 6'h16: return M_BLEZ;
      6'h07, 6'h17: return M_BGTZ;
      6'h08: return M_ADDI;   6'h09: return M_ADDIU;  6'h0A: return M_SLTI;
      6'h0B: return M_SLTIU;  6'h0C: return M_ANDI;   6'h0D: return M_ORI;
      6'h0E: return M_XORI;   6'h0F: return M_LUI;
      6'h10, 6'h11, 6'h13: return M_PASS;
      6'h18: return M_DADDI;  6'h19: return M_DADDIU;
      default: return M_UNK;
    endcase
  endfunction

  function automatic logic [63:0] sx32(input logic [31:0] v);
    longint t;
    t = int'(v);
    return t;
  endfunction

  function automatic logic ovf32(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic ovf66(input logic signed [65:0] w);
    return (w > 66'sd9223372036854775807) || (w < -66'sd9223372036854775808);
  endfunction

  // Reference model: works on mathematical signed values and range checks.
  function automatic res_t model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] lnk, input logic kill);
    res_t        x;
    mn_t         m;
    int          sh;
    longint      s;
    longint      ia;
    logic [63:0] si;
    logic signed [65:0] wa;
    logic signed [65:0] wb;
    logic signed [65:0] wi;
    x  = '0;
    m  = decode(ins);
    sh = int'(ins[10:6]);
    ia = longint'(int'(a[31:0]));
    si = longint'(shortint'(ins[15:0]));
    wa = $signed({{2{a[63]}}, a});
    wb = $signed({{2{b[63]}}, b});
    wi = $signed({{2{si[63]}}, si});
    if (kill) return x;
    case (m)
      M_PASS:   x.r = b;
      M_MEM:    x.r = a + si;
      M_SLL:    x.r = sx32(b[31:0] << sh);
      M_SRL:    x.r = sx32(b[31:0] >> sh);
      M_SRA:    x.r = sx32(int'(b[31:0]) >>> sh);
      M_SLLV:   x.r = sx32(b[31:0] << a[4:0]);
      M_SRLV:   x.r = sx32(b[31:0] >> a[4:0]);
      M_SRAV:   x.r = sx32(int'(b[31:0]) >>> a[4:0]);
      M_DSLL:   x.r = b << sh;
      M_DSRL:   x.r = b >> sh;
      M_DSRA:   x.r = longint'(b) >>> sh;
      M_DSLL32: x.r = b << (sh + 32);
      M_DSRL32: x.r = b >> (sh + 32);
      M_DSRA32: x.r = longint'(b) >>> (sh + 32);
      M_DSLLV:  x.r = b << a[5:0];
      M_DSRLV:  x.r = b >> a[5:0];
      M_DSRAV:  x.r = longint'(b) >>> a[5:0];
      M_ADD, M_ADDU: begin
        s = ia + longint'(int'(b[31:0]));
        x.r = sx32(s[31:0]);
        x.o = (m == M_ADD) && ovf32(s);
      end
      M_SUB, M_SUBU: begin
        s = ia - longint'(int'(b[31:0]));
        x.r = sx32(s[31:0]);
        x.o = (m == M_SUB) && ovf32(s);
      end
      M_ADDI, M_ADDIU: begin
        s = ia + longint'(shortint'(ins[15:0]));
        x.r = sx32(s[31:0]);
        x.o = (m == M_ADDI) && ovf32(s);
      end
      M_DADD, M_DADDU: begin
        x.r = a + b;
        x.o = (m == M_DADD) && ovf66(wa + wb);
      end
      M_DSUB, M_DSUBU: begin
        x.r = a - b;
        x.o = (m == M_DSUB) && ovf66(wa - wb);
      end
      M_DADDI, M_DADDIU: begin
        x.r = a + si;
        x.o = (m == M_DADDI) && ovf66(wa + wi);
      end
      M_AND:   x.r = a & b;
      M_OR:    x.r = a | b;
      M_XOR:   x.r = a ^ b;
      M_NOR:   x.r = ~(a | b);
      M_SLT:   x.r = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
      M_SLTU:  x.r = (a < b) ? 64'd1 : 64'd0;
      M_SLTI:  x.r = (longint'(a) < longint'(si)) ? 64'd1 : 64'd0;
      M_SLTIU: x.r = (a < si) ? 64'd1 : 64'd0;
      M_ANDI:  x.r = a & 64'(ins[15:0]);
      M_ORI:   x.r = a | 64'(ins[15:0]);
      M_XORI:  x.r = a ^ 64'(ins[15:0]);
      M_LUI:   x.r = longint'(int'({ins[15:0], 16'h0000}));
      M_J, M_JR: x.c = 1'b1;
      M_JAL, M_JALR: begin
        x.r = lnk;
        x.c = 1'b1;
      end
      M_BEQ:  x.c = (a == b);
      M_BNE:  x.c = (a != b);
      M_BLEZ: x.c = (longint'(a) <= 0);
      M_BGTZ: x.c = (longint'(a) > 0);
      M_BLTZ: x.c = (longint'(a) < 0);
      M_BGEZ: x.c = (longint'(a) >= 0);
      M_BLTZAL: begin
        x.c = (longint'(a) < 0);
        x.r = lnk;
      end
      M_BGEZAL: begin
        x.c = (longint'(a) >= 0);
        x.r = lnk;
      end
      default: ;
    endcase
    return x;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1: return 64'h0000_0000_7FFF_FFFF;
      2: return 64'hFFFF_FFFF_8000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      5: return 64'(longint'($urandom_range(0, 3)) - 2);
      6: return 64'($urandom_range(0, 127));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] lnk, input logic kill);
    exinstr  = ins;
    exr0     = a;
    exr1     = b;
    exlink   = lnk;
    exdec    = 16'($urandom);
    exdec[0] = kill;
  endtask

  task automatic step(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] lnk, input logic kill);
    @(negedge clk);
    drive(ins, a, b, lnk, kill);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] er, input logic eo, input logic ec);
    n_tests++;
    assert (exalur === er) else begin
      n_fail++;
      $error("FAIL %s exalur got %h expected %h", tag, exalur, er);
    end
    n_tests++;
    assert (exovfl === eo) else begin
      n_fail++;
      $error("FAIL %s exovfl got %b expected %b", tag, exovfl, eo);
    end
    n_tests++;
    assert (exbcmp === ec) else begin
      n_fail++;
      $error("FAIL %s exbcmp got %b expected %b", tag, exbcmp, ec);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] lnk;
    logic        kill;
    res_t        e;

    reset = 1'b0;
    drive(32'h2008_0100, 64'd0, 64'd0, 64'd0, 1'b0);
    #2;
    chk("reset_initial", 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held", 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("first_after_reset_addi", 64'h100, 1'b0, 1'b0);

    step(32'h2008_0100, 64'd0, 64'd5, 64'd0, 1'b0);
    chk("addi", 64'h100, 1'b0, 1'b0);
    step(32'h8D09_0004, 64'h100, 64'd7, 64'd0, 1'b0);
    chk("lw", 64'h104, 1'b0, 1'b0);
    step(32'hAD09_0004, 64'h100, 64'd7, 64'd0, 1'b0);
    chk("sw", 64'h104, 1'b0, 1'b0);
    step(32'h0000_0020, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0);
    chk("add_ovf", 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);
    step(32'h0000_0021, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0);
    chk("addu_wrap", 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    step(32'h1000_0000, 64'd5, 64'd5, 64'd0, 1'b0);
    chk("beq_taken", 64'd0, 1'b0, 1'b1);
    step(32'h1400_0000, 64'd5, 64'd5, 64'd0, 1'b0);
    chk("bne_not_taken", 64'd0, 1'b0, 1'b0);
    step(32'h0400_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 1'b0);
    chk("bltz_min", 64'd0, 1'b0, 1'b1);
    step(32'h0C00_0000, 64'd3, 64'd4, 64'h8000_0010, 1'b0);
    chk("jal_link", 64'h8000_0010, 1'b0, 1'b1);
    step(32'h0000_003F, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 1'b0);
    chk("dsra32", 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    step(32'h0000_0014, 64'h41, 64'd1, 64'd0, 1'b0);
    chk("dsllv", 64'd2, 1'b0, 1'b0);
    step(32'h0000_0020, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b1);
    chk("kill_add_ovf", 64'd0, 1'b0, 1'b0);

    step(32'h0000_0020, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0);
    chk("pre_async_reset", 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_before_edge", 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("async_reset_held", 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(32'h2008_0100, 64'd0, 64'd0, 64'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("release_first_result", 64'h100, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      for (int t = 0; t < 20; t++) begin
        ins = $urandom;
        case ($urandom_range(0, 9))
          0, 1, 2, 3: ins[31:26] = 6'h00;
          4:          ins[31:26] = 6'h01;
          default: ;
        endcase
        if (decode(ins) != M_UNK || $urandom_range(0, 9) == 0) break;
      end
      a    = rnd_op();
      b    = ($urandom_range(0, 3) == 0) ? a : rnd_op();
      lnk  = {$urandom, $urandom};
      kill = ($urandom_range(0, 9) == 0);
      e    = model(ins, a, b, lnk, kill);
      step(ins, a, b, lnk, kill);
      chk($sformatf("rnd%0d_%s_%h", i, decode(ins).name(), ins), e.r, e.o, e.c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_alu.md
EX_ALU -- requirements
Module: ex_alu

Interface
REQ-001 SHALL have port clk, in, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, in, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port exdec, in, `DECMAX+1 bits: decode flags; bit 0 = kill (instruction squashed); other bits ignored.
REQ-004 SHALL have port exinstr, in, 32 bits: MIPS III instruction currently in EX.
REQ-005 SHALL have port exr0, in, 64 bits: forwarded rs operand.
REQ-006 SHALL have port exr1, in, 64 bits: forwarded rt operand.
REQ-007 SHALL have port exlink, in, 64 bits: link address (PC+8).
REQ-008 SHALL have port exalur, out, 64 bits: registered ALU result or effective address.
REQ-009 SHALL have port exovfl, out, 1 bit: registered signed-overflow trap flag.
REQ-010 SHALL have port exbcmp, out, 1 bit: registered branch-condition-true flag.

Function
REQ-011 SHALL decode the operation from exinstr alone (opcode [31:26], funct [5:0], REGIMM rt [20:16]); imm = exinstr[15:0]; sa = exinstr[10:6].
REQ-012 SHALL register all outputs on every rising clk edge; latency is exactly 1 cycle, there is no stall input and no handshake.
REQ-013 SHALL force exalur = 0, exovfl = 0 and exbcmp = 0 on the next edge when exdec[0] = 1.
REQ-014 SHALL compute 32-bit ops (ADD/ADDU/SUB/SUBU/ADDI/ADDIU, SLL/SRL/SRA/SLLV/SRLV/SRAV) on bits [31:0] and sign-extend bit 31 of the result to 64 bits.
REQ-015 SHALL compute 64-bit ops: DADD/DADDU/DSUB/DSUBU/DADDI/DADDIU, AND/OR/XOR/NOR, ANDI/ORI/XORI (imm zero-extended), SLT/SLTU/SLTI/SLTIU (imm sign-extended; result 0 or 1), LUI (sext(imm<<16)).
REQ-016 SHALL compute 64-bit shifts: DSLL/DSRL/DSRA by sa; DSLL32/DSRL32/DSRA32 by sa+32; DSLLV/DSRLV/DSRAV by exr0[5:0]. 32-bit variable shifts SHALL use exr0[4:0].
REQ-017 SHALL take shift operands from exr1 and all other first operands from exr0.
REQ-018 SHALL output exr0 + sext(imm), full 64-bit, for every load/store opcode (LB..LD, SB..SD, LWL/LWR/LDL/LDR, LL/SC, cache, COP1 loads and stores).
REQ-019 SHALL output exalur = exlink for JAL, JALR, BLTZAL, BGEZAL, BLTZALL and BGEZALL.
REQ-020 SHALL set exovfl only for ADD, ADDI, SUB, DADD, DADDI and DSUB on signed overflow (32-bit overflow for the 32-bit forms); exalur SHALL still carry the wrapped, sign-extended value.
REQ-021 SHALL set exbcmp for: BEQ(L) exr0==exr1; BNE(L) !=; BLEZ(L) exr0<=0; BGTZ(L) >0; BLTZ(AL)(L) <0; BGEZ(AL)(L) >=0; all compares signed 64-bit. J/JAL/JR/JALR SHALL give exbcmp = 1.
REQ-022 SHALL give exbcmp = 0 and exovfl = 0 for all non-branch, non-trapping ops; unrecognised opcodes SHALL give exalur = 0.
REQ-023 SHALL leave MULT/DIV/HI/LO, COP0/COP1 arithmetic and FP outside this block; these opcodes SHALL give exalur = exr1.

Reset
REQ-024 SHALL clear exalur, exovfl and exbcmp to 0 immediately when reset = 0, independent of clk.
REQ-025 SHALL hold all outputs at 0 while reset = 0; the first computed result SHALL appear on the first rising edge after reset returns to 1.

Verification
REQ-026 SHALL pass: exinstr = 0x20080100 (ADDI), exr0 = 0 -> exalur = 0x100, exovfl = 0 after one edge.
REQ-027 SHALL pass: exinstr = 0x8D090004 (LW), exr0 = 0x100 -> exalur = 0x104; 0xAD090004 (SW) gives the same result.
REQ-028 SHALL pass: ADD with exr0 = 0x7FFFFFFF, exr1 = 1 -> exovfl = 1, exalur = 0xFFFFFFFF80000000; ADDU with the same operands -> same exalur, exovfl = 0.
REQ-029 SHALL pass: BEQ with exr0 = exr1 = 5 -> exbcmp = 1; BNE with the same operands -> 0; BLTZ with exr0 = 0x8000000000000000 -> 1; JAL with exlink = 0x8000_0010 -> exalur = 0x80000010.
REQ-030 SHALL pass: DSRA32 with exr1 = 0x8000000000000000, sa = 0 -> 0xFFFFFFFF80000000; DSLLV with exr0 = 0x41, exr1 = 1 -> 2.
REQ-031 SHALL pass: exdec[0] = 1 on an ADD overflow case -> all outputs 0; reset driven low mid-stream -> all outputs 0 before the next edge.
